// File: rtl/mips32_shift_pkg.sv
// Shared definitions for the MIPS32 multi-cycle shift sequencer:
// shift-op encoding and the controller state type.
package mips32_shift_pkg;

    // Shift select encoding carried on req_op
    localparam logic [1:0] SHIFT_NONE = 2'd0;
    localparam logic [1:0] SHIFT_SLL  = 2'd1;
    localparam logic [1:0] SHIFT_SR   = 2'd2;
    localparam logic [1:0] SHIFT_ROR  = 2'd3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/mips32_shift_stage.sv
// Single combinational shift stage: shifts by 0..STEP positions for
// logic-left, right (arith/logic fill) and rotate-right, then selects by op.
// AMT_W is the width needed to carry a step amount of 0..STEP.
module mips32_shift_stage
    import mips32_shift_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int AMT_W     = 4
) (
    input  logic [DATAWIDTH-1:0] data,
    input  logic [1:0]           op,
    input  logic                 arith,
    input  logic [AMT_W-1:0]     amt,
    output logic [DATAWIDTH-1:0] result
);

    logic                 fill;
    logic [DATAWIDTH-1:0] sll_res;
    logic [DATAWIDTH-1:0] sr_res;
    logic [DATAWIDTH-1:0] ror_res;

    // Compute all three shifted forms and pick the requested one.
    // Right shift and rotate are taken from the low half of a double-width
    // word whose top half holds the fill bits (or the operand itself).
    always_comb begin
        fill    = arith & data[DATAWIDTH-1];
        sll_res = data << amt;
        sr_res  = DATAWIDTH'({{DATAWIDTH{fill}}, data} >> amt);
        ror_res = DATAWIDTH'({data, data} >> amt);
        case (op)
            SHIFT_SLL: result = sll_res;
            SHIFT_SR:  result = sr_res;
            SHIFT_ROR: result = ror_res;
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/mips32_shift_ctrl.sv
// Multi-cycle shift sequencer. Accepts one request (valid/ready), walks the
// shift amount down at most STEP bits per cycle through one shift stage, then
// holds the result on a valid/ready response port until consumed.
// Handshakes: a transfer occurs on a rising clk edge where valid and ready are
// both high; valid/data stay stable while ready is low.
// Optional: define MIPS32_SHIFT_CTRL_STATS_EN to add stat_ops/stat_cycles.
module mips32_shift_ctrl
    import mips32_shift_pkg::*;
#(
    parameter  int DATAWIDTH = 32,
    parameter  int STEP      = 8,
    localparam int SHAMT_W   = $clog2(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic                 req_arith,
    input  logic [SHAMT_W-1:0]   req_shamt,
    input  logic [DATAWIDTH-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 busy
`ifdef MIPS32_SHIFT_CTRL_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [31:0]          stat_cycles
`endif
);

    localparam int AMT_W = $clog2(STEP + 1);

    shift_state_e         state;
    logic [DATAWIDTH-1:0] data_q;
    logic [1:0]           op_q;
    logic                 arith_q;
    logic [SHAMT_W-1:0]   rem_q;
    logic [DATAWIDTH-1:0] rsp_data_q;

    logic [AMT_W-1:0]     step_amt;
    logic                 last_step;
    logic [DATAWIDTH-1:0] stage_out;

    // Per-cycle step is min(rem, STEP); the step that exhausts rem is the last.
    always_comb begin
        last_step = (32'(rem_q) <= STEP);
        if (last_step) begin
            step_amt = AMT_W'(rem_q);
        end else begin
            step_amt = AMT_W'(STEP);
        end
    end

    mips32_shift_stage #(
        .DATAWIDTH (DATAWIDTH),
        .AMT_W     (AMT_W)
    ) u_stage (
        .data   (data_q),
        .op     (op_q),
        .arith  (arith_q),
        .amt    (step_amt),
        .result (stage_out)
    );

    // Sequencer: accept in IDLE, iterate in SHIFT, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= '0;
            op_q       <= SHIFT_NONE;
            arith_q    <= 1'b0;
            rem_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        data_q  <= req_data;
                        op_q    <= req_op;
                        arith_q <= req_arith;
                        rem_q   <= req_shamt;
                        if (req_shamt == '0 || req_op == SHIFT_NONE) begin
                            state      <= DONE;
                            rsp_data_q <= req_data;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= stage_out;
                    rem_q  <= rem_q - SHAMT_W'(step_amt);
                    if (last_step) begin
                        state      <= DONE;
                        rsp_data_q <= stage_out;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == DONE);
        rsp_data  = rsp_data_q;
    end

`ifdef MIPS32_SHIFT_CTRL_STATS_EN
    // Activity counters: completed responses and busy cycles, both wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops    <= '0;
            stat_cycles <= '0;
        end else begin
            if (state == DONE && rsp_ready) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (state != IDLE) begin
                stat_cycles <= stat_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips32_shift_ctrl.sv
// Self-checking bench for mips32_shift_ctrl (DATAWIDTH=32, STEP=8).
module tb_mips32_shift_ctrl;

    localparam int W    = 32;
    localparam int STEP = 8;
    localparam int SW   = 5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic          req_arith = 1'b0;
    logic [SW-1:0] req_shamt = '0;
    logic [W-1:0]  req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_data;
    logic          busy;
`ifdef MIPS32_SHIFT_CTRL_STATS_EN
    logic [15:0]   stat_ops;
    logic [31:0]   stat_cycles;
`endif

    int checks = 0;
    int errors = 0;
    bit rand_bp = 1'b0;

    always #5 clk = ~clk;

    mips32_shift_ctrl #(.DATAWIDTH(W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_arith (req_arith),
        .req_shamt (req_shamt),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef MIPS32_SHIFT_CTRL_STATS_EN
        ,
        .stat_ops    (stat_ops),
        .stat_cycles (stat_cycles)
`endif
    );

    // ---------------- reference model ----------------
    // Single shift by the full amount, bit by bit from the definition.
    function automatic logic [W-1:0] shift_ref(input logic [1:0] op, input logic arith,
                                               input int sh, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        if (op != 2'd0) begin
            for (int i = 0; i < W; i++) begin
                case (op)
                    2'd1:    r[i] = (i >= sh) ? d[i-sh] : 1'b0;
                    2'd2:    r[i] = (i + sh < W) ? d[i+sh] : (arith & d[W-1]);
                    default: r[i] = d[(i + sh) % W];
                endcase
            end
        end
        return r;
    endfunction

    // Number of SHIFT cycles an operation occupies.
    function automatic int n_steps(input logic [1:0] op, input int sh);
        return (op == 2'd0 || sh == 0) ? 0 : (sh + STEP - 1) / STEP;
    endfunction

    logic [W-1:0] model_ref;
    int           model_n;
    always_comb begin
        model_ref = shift_ref(req_op, req_arith, int'(req_shamt), req_data);
        model_n   = n_steps(req_op, int'(req_shamt));
    end

    // Cycle-level behaviour: busy from accept until response handshake,
    // response visible after n_steps further edges.
    logic [W-1:0] exp_q[$];
    bit           m_busy;
    bit           m_valid;
    int           m_cnt;
    logic [W-1:0] m_rsp;
    int           m_ops;
    int           m_cycles;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_cnt    <= 0;
            m_rsp    <= '0;
            m_ops    <= 0;
            m_cycles <= 0;
            exp_q.delete();
        end else begin
            if (m_busy) m_cycles <= m_cycles + 1;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy <= 1'b1;
                    if (model_n == 0) begin
                        m_valid <= 1'b1;
                        m_rsp   <= model_ref;
                    end else begin
                        exp_q.push_back(model_ref);
                        m_cnt <= model_n;
                    end
                end
            end else if (m_valid) begin
                if (rsp_ready) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                    m_ops   <= m_ops + 1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_valid <= 1'b1;
                    m_rsp   <= exp_q.pop_front();
                end
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle: compare DUT to the model at the falling edge,
    // then drive new inputs just after it.
    task automatic tick();
        @(negedge clk);
        chk("cyc_req_ready", W'(req_ready), W'(!m_busy));
        chk("cyc_busy",      W'(busy),      W'(m_busy));
        chk("cyc_rsp_valid", W'(rsp_valid), W'(m_valid));
        chk("cyc_rsp_data",  rsp_data,      m_rsp);
`ifdef MIPS32_SHIFT_CTRL_STATS_EN
        chk("cyc_stat_ops",    W'(stat_ops),    W'(16'(m_ops)));
        chk("cyc_stat_cycles", W'(stat_cycles), W'(m_cycles));
`endif
        #1;
        if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present a request and return right after the accept edge (cycle 1).
    task automatic issue(input logic [1:0] op, input logic arith, input int sh,
                         input logic [W-1:0] d);
        int n;
        req_op    = op;
        req_arith = arith;
        req_shamt = SW'(sh);
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) chk("accept_timeout", W'(req_ready), W'(1));
        tick();
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_arith = 1'($urandom_range(0, 1));
        req_shamt = SW'($urandom_range(0, W - 1));
        req_data  = $urandom;
    endtask

    // Directed operation with literal result and latency.
    task automatic run_op(input string nm, input logic [1:0] op, input logic arith,
                          input int sh, input logic [W-1:0] d,
                          input logic [W-1:0] exp, input int lat);
        int cyc;
        chk({nm, "_model"}, shift_ref(op, arith, sh, d), exp);
        issue(op, arith, sh, d);
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, W'(cyc), W'(lat));
        chk({nm, "_data"}, rsp_data, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        chk("reset_req_ready", W'(req_ready), W'(1));
        chk("reset_busy",      W'(busy),      W'(0));
        chk("reset_rsp_valid", W'(rsp_valid), W'(0));
        chk("reset_rsp_data",  rsp_data,      W'(0));
        rst = 1'b0;
        tick();

        run_op("sll31",  2'd1, 1'b0, 31, 32'h0000_0001, 32'h8000_0000, 5);
        run_op("sra4",   2'd2, 1'b1, 4,  32'h8000_0000, 32'hF800_0000, 2);
        run_op("srl4",   2'd2, 1'b0, 4,  32'h8000_0000, 32'h0800_0000, 2);
        run_op("ror12",  2'd3, 1'b0, 12, 32'h1234_5678, 32'h6781_2345, 3);
        run_op("sra12",  2'd2, 1'b1, 12, 32'h8765_4321, 32'hFFF8_7654, 3);
        run_op("sh0",    2'd1, 1'b0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        chk("sh0_req_ready_done", W'(req_ready), W'(0));
        run_op("nop5",   2'd0, 1'b0, 5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        chk("nop5_req_ready_done", W'(req_ready), W'(0));
        tick();

        // Backpressure in DONE with a competing request pending
        rsp_ready = 1'b0;
        run_op("bp_sll8", 2'd1, 1'b0, 8, 32'h0000_000F, 32'h0000_0F00, 2);
        req_op    = 2'd0;
        req_arith = 1'b0;
        req_shamt = SW'(3);
        req_data  = 32'hA5A5_A5A5;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_rsp_valid", W'(rsp_valid), W'(1));
            chk("bp_rsp_data",  rsp_data,      32'h0000_0F00);
            chk("bp_req_ready", W'(req_ready), W'(0));
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_after_hs_ready", W'(req_ready), W'(1));
        chk("bp_after_hs_valid", W'(rsp_valid), W'(0));
        tick();
        req_valid = 1'b0;
        chk("bp_next_busy",  W'(busy),      W'(1));
        chk("bp_next_valid", W'(rsp_valid), W'(1));
        chk("bp_next_data",  rsp_data,      32'hA5A5_A5A5);
        tick();
        tick();

        // Reset during the second SHIFT cycle
        issue(2'd1, 1'b0, 31, 32'h0000_0001);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy",      W'(busy),      W'(0));
        chk("rst_mid_req_ready", W'(req_ready), W'(1));
        chk("rst_mid_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_mid_rsp_data",  rsp_data,      W'(0));
`ifdef MIPS32_SHIFT_CTRL_STATS_EN
        chk("rst_mid_stat_ops",  W'(stat_ops),  W'(0));
`endif
        tick();
        rst = 1'b0;
        tick();
        run_op("post_rst_sll1", 2'd1, 1'b0, 1, 32'h0000_0001, 32'h0000_0002, 2);
        tick();
`ifdef MIPS32_SHIFT_CTRL_STATS_EN
        chk("post_rst_stat_ops", W'(stat_ops), W'(1));
`endif

        // Randomized traffic with random response backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 250; k++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, W - 1), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_bp = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 60 && busy; n++) tick();
        chk("drain_idle", W'(busy), W'(0));
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
